// File: rtl/pifo_pkg.sv
// Shared constants for the PIFO enqueue controller: default queue count,
// priority / descriptor / counter widths, drop threshold, and the helper
// that turns a queue count into a queue-ID width.
package pifo_pkg;

  localparam int PIFO_NUMQ_DEF        = 1024;
  localparam int PIFO_BITPRIO_DEF     = 16;
  localparam int PIFO_BITDESC_DEF     = 32;
  localparam int PIFO_BITCNT_DEF      = 16;
  localparam int PIFO_DROP_THRESH_DEF = 1000;

  // Queue-ID width for a given queue count; never collapses to zero bits.
  function automatic int qid_width(input int numq);
    return (numq > 1) ? $clog2(numq) : 1;
  endfunction

endpackage : pifo_pkg

// File: rtl/pifo_enq_cnt_mem.sv
// Per-queue packet counter array. Two combinational read ports, one
// increment port and one decrement port. When both write ports hit the
// same queue in the same cycle they cancel and the entry is left alone.
module pifo_enq_cnt_mem
  import pifo_pkg::*;
#(
  parameter  int NUMQ   = PIFO_NUMQ_DEF,
  parameter  int BITCNT = PIFO_BITCNT_DEF,
  localparam int QW     = qid_width(NUMQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [QW-1:0]     i_rd0_addr,
  output logic [BITCNT-1:0] o_rd0_data,
  input  logic [QW-1:0]     i_rd1_addr,
  output logic [BITCNT-1:0] o_rd1_data,
  input  logic              i_inc_en,
  input  logic [QW-1:0]     i_inc_addr,
  input  logic              i_dec_en,
  input  logic [QW-1:0]     i_dec_addr
);

  logic [BITCNT-1:0] r_cnt [NUMQ];
  logic              w_merge;

  assign o_rd0_data = r_cnt[i_rd0_addr];
  assign o_rd1_data = r_cnt[i_rd1_addr];

  // An increment and a decrement on the same entry net to zero.
  assign w_merge = i_inc_en && i_dec_en && (i_inc_addr == i_dec_addr);

  // Counter update with asynchronous clear of every entry.
  // NOTE: this array must come out of reset all-zero (a stale count would
  // block or mis-account a queue), so it is built from resettable flops
  // rather than left uninitialised like a plain RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUMQ; i++) r_cnt[i] <= '0;
    end else begin
      if (i_inc_en && !w_merge) r_cnt[i_inc_addr] <= r_cnt[i_inc_addr] + BITCNT'(1);
      if (i_dec_en && !w_merge) r_cnt[i_dec_addr] <= r_cnt[i_dec_addr] - BITCNT'(1);
    end
  end

endmodule : pifo_enq_cnt_mem

// File: rtl/pifo_enq_ctrl.sv
// PIFO enqueue controller. Accepts arrivals, tracks per-queue and total
// occupancy, issues one push per accepted arrival toward the PIFO, flags
// queue-drained events and raises a drop request above a threshold.
// Optional statistics counters are built when PIFO_ENQ_STATS_EN is defined;
// otherwise the stat ports are tied to zero.
module pifo_enq_ctrl
  import pifo_pkg::*;
#(
  parameter  int NUMQ        = PIFO_NUMQ_DEF,
  parameter  int BITPRIO     = PIFO_BITPRIO_DEF,
  parameter  int BITDESC     = PIFO_BITDESC_DEF,
  parameter  int BITCNT      = PIFO_BITCNT_DEF,
  parameter  int DROP_THRESH = PIFO_DROP_THRESH_DEF,
  localparam int QW          = qid_width(NUMQ),
  localparam int TW          = BITCNT + QW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_enq_valid,
  output logic               s_enq_ready,
  input  logic [QW-1:0]      s_enq_qid,
  input  logic [BITPRIO-1:0] s_enq_prio,
  input  logic               deq_valid,
  input  logic [QW-1:0]      deq_qid,
  output logic               pifo_in_valid,
  input  logic               pifo_in_ready,
  output logic [BITPRIO-1:0] pifo_in_prio,
  output logic [BITDESC-1:0] pifo_in_data,
  output logic               pifo_in_drop,
  output logic               pifo_in_empty,
  output logic [BITDESC-1:0] pifo_in_empty_data,
  output logic               err_underflow,
  output logic [31:0]        stat_enq,
  output logic [31:0]        stat_drop_cycles
);

  localparam logic [31:0] DROP_TH = 32'(DROP_THRESH);

  logic [BITCNT-1:0]  w_cnt_enq;
  logic [BITCNT-1:0]  w_cnt_deq;
  logic               w_push_stall;
  logic               w_accept;
  logic               w_deq_ok;
  logic               w_deq_uf;
  logic               w_same_q;
  logic               w_empty_evt;
  logic [TW-1:0]      w_total_nxt;

  logic [TW-1:0]      r_total;
  logic               r_valid;
  logic [BITPRIO-1:0] r_prio;
  logic [BITDESC-1:0] r_data;
  logic               r_drop;
  logic               r_empty;
  logic [BITDESC-1:0] r_empty_data;
  logic               r_underflow;

  pifo_enq_cnt_mem #(
    .NUMQ   (NUMQ),
    .BITCNT (BITCNT)
  ) u_cnt_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd0_addr (s_enq_qid),
    .o_rd0_data (w_cnt_enq),
    .i_rd1_addr (deq_qid),
    .o_rd1_data (w_cnt_deq),
    .i_inc_en   (w_accept),
    .i_inc_addr (s_enq_qid),
    .i_dec_en   (w_deq_ok),
    .i_dec_addr (deq_qid)
  );

  // A pending push that the PIFO has not taken blocks new arrivals, as does
  // a queue whose counter is already saturated.
  assign w_push_stall = r_valid && !pifo_in_ready;
  assign s_enq_ready  = !w_push_stall && (w_cnt_enq != '1);
  assign w_accept     = s_enq_valid && s_enq_ready;

  // A dequeue against an empty queue is ignored and reported as underflow.
  assign w_deq_ok     = deq_valid && (w_cnt_deq != '0);
  assign w_deq_uf     = deq_valid && (w_cnt_deq == '0);
  assign w_same_q     = w_accept && w_deq_ok && (s_enq_qid == deq_qid);
  assign w_empty_evt  = w_deq_ok && (w_cnt_deq == BITCNT'(1)) && !w_same_q;

  // Post-update total occupancy, used both for the register and the drop level.
  // NOTE: default assignment first so no path leaves the output unassigned
  // and a latch is never inferred.
  always_comb begin
    w_total_nxt = r_total;
    case ({w_accept, w_deq_ok})
      2'b10:   w_total_nxt = r_total + TW'(1);
      2'b01:   w_total_nxt = r_total - TW'(1);
      default: w_total_nxt = r_total;
    endcase
  end

  // Occupancy, drop level, underflow flag and drained-queue pulse.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total      <= '0;
      r_drop       <= 1'b0;
      r_underflow  <= 1'b0;
      r_empty      <= 1'b0;
      r_empty_data <= '0;
    end else begin
      r_total <= w_total_nxt;
      r_drop  <= (32'(w_total_nxt) >= DROP_TH);
      r_empty <= w_empty_evt;
      if (w_deq_uf)    r_underflow  <= 1'b1;
      if (w_empty_evt) r_empty_data <= BITDESC'(deq_qid);
    end
  end

  // Push register: load on accept, hold while stalled, clear after handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_prio  <= '0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_prio  <= s_enq_prio;
      r_data  <= BITDESC'(s_enq_qid);
    end else if (pifo_in_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign pifo_in_valid      = r_valid;
  assign pifo_in_prio       = r_prio;
  assign pifo_in_data       = r_data;
  assign pifo_in_drop       = r_drop;
  assign pifo_in_empty      = r_empty;
  assign pifo_in_empty_data = r_empty_data;
  assign err_underflow      = r_underflow;

`ifdef PIFO_ENQ_STATS_EN
  logic [31:0] r_stat_enq;
  logic [31:0] r_stat_drop;

  // Free-running statistics, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_enq  <= '0;
      r_stat_drop <= '0;
    end else begin
      if (w_accept) r_stat_enq  <= r_stat_enq + 32'd1;
      if (r_drop)   r_stat_drop <= r_stat_drop + 32'd1;
    end
  end

  assign stat_enq         = r_stat_enq;
  assign stat_drop_cycles = r_stat_drop;
`else
  assign stat_enq         = '0;
  assign stat_drop_cycles = '0;
`endif

endmodule : pifo_enq_ctrl

// File: doc/pifo_enq_ctrl.md
PIFO_ENQ_CTRL -- requirements
Module: pifo_enq_ctrl

Interface
REQ-001 SHALL have parameter NUMQ, default 1024, number of queue IDs.
REQ-002 SHALL have parameter BITPRIO, default 16, priority width.
REQ-003 SHALL have parameter BITDESC, default 32, queue-ID field width toward PIFO.
REQ-004 SHALL have parameter BITCNT, default 16, per-queue packet counter width.
REQ-005 SHALL have parameter DROP_THRESH, default 1000, total-occupancy drop threshold.
REQ-006 SHALL have ports, clock and reset first:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_enq_valid / s_enq_ready  in/out  1  arrival handshake.
- s_enq_qid  in  $clog2(NUMQ)  arriving queue ID.
- s_enq_prio  in  BITPRIO  arriving priority.
- deq_valid  in  1  one packet consumed; no ready.
- deq_qid  in  $clog2(NUMQ)  consumed queue ID.
- pifo_in_valid / pifo_in_ready  out/in  1  push handshake.
- pifo_in_prio  out  BITPRIO  push priority.
- pifo_in_data  out  BITDESC  push queue ID, zero-extended.
- pifo_in_drop  out  1  drop-request level.
- pifo_in_empty  out  1  queue-drained pulse.
- pifo_in_empty_data  out  BITDESC  drained queue ID.
- err_underflow  out  1  sticky deq-on-empty flag.

Function
REQ-007 SHALL keep cnt[NUMQ] (BITCNT bits each) and total (BITCNT+$clog2(NUMQ) bits).
REQ-008 SHALL accept an arrival when s_enq_valid && s_enq_ready.
- s_enq_ready = !(pifo_in_valid && !pifo_in_ready) && cnt[s_enq_qid] != all-ones.
REQ-009 On accept, SHALL increment cnt[qid] and total.
- One cycle later: pifo_in_valid=1, pifo_in_prio=s_enq_prio, pifo_in_data=qid.
REQ-010 SHALL hold pifo_in_valid/prio/data stable while pifo_in_ready=0; valid clears after the handshake unless a new accept occurs in the same cycle.
REQ-011 SHALL process deq_valid every cycle, regardless of pifo_in_ready.
- cnt[deq_qid]=0: cnt unchanged, err_underflow set.
- Otherwise: cnt[deq_qid] and total decrement.
REQ-012 When a deq drops cnt from 1 to 0, SHALL pulse pifo_in_empty for exactly one cycle, the following cycle, with pifo_in_empty_data=deq_qid.
REQ-013 Arrival and deq on the same qid in the same cycle:
- net cnt and total unchanged.
- no empty pulse.
- push still issued.
REQ-014 Arrival and deq on different qids in the same cycle SHALL both take effect.
REQ-015 SHALL register pifo_in_drop = (total >= DROP_THRESH), evaluated on post-update values.
REQ-016 Counters SHALL never wrap; saturation is prevented by REQ-008 and REQ-011.

Reset
REQ-017 rst_n=0 SHALL asynchronously clear cnt[], total, err_underflow, pifo_in_valid, pifo_in_drop and pifo_in_empty; data and prio outputs go to 0.
REQ-018 Reset mid-operation SHALL discard any pending push; the first accept after release behaves as on an empty block.

Configuration
REQ-019 With macro PIFO_ENQ_STATS_EN defined, SHALL add outputs stat_enq (32 bits, accepted arrivals) and stat_drop_cycles (32 bits, cycles with pifo_in_drop=1).
- Both wrap modulo 2^32 and are cleared by reset.
REQ-020 With PIFO_ENQ_STATS_EN undefined, SHALL omit the counters; stat ports are driven 0.

Structure
REQ-021 Shared package pifo_pkg SHALL hold the qid/priority/count width constants and the DROP_THRESH default.
REQ-022 SHALL instantiate one sub-module, pifo_enq_cnt_mem: counter array with 2 combinational read ports, 2 write ports and same-address merge.

Verification
REQ-023 Bench SHALL cover:
- Reset, then arrival qid=5 prio=7: next cycle pifo_in_valid=1, data=5, prio=7; cnt[5]=1.
- cnt[5]=1, deq qid=5: next cycle pifo_in_empty=1 (single cycle), empty_data=5; cnt[5]=0.
- Deq qid=9 with cnt[9]=0: err_underflow=1 and stays 1; total unchanged.
- pifo_in_ready=0 for 4 cycles with a push pending: s_enq_ready=0, outputs held; releases one cycle after ready=1.
- Same-cycle arrival and deq on qid=3 with cnt[3]=1: cnt[3]=1, push issued, no empty pulse.
- DROP_THRESH=4, 4 arrivals: pifo_in_drop=1 after the 4th; one deq gives pifo_in_drop=0 next cycle.
